sw_key_decoder: RTL and testbench

- Upstream input stage between the Basys3 slide switches and the game/lock core.
- Synchronises and debounces the 16-bit switch bank, then converts a one-hot switch press into a single-cycle key event carrying the 4-bit switch index (sw[9] -> 9, sw[11] -> 0xB).
- Rejects multi-switch presses and requires a full release before the next key.
- Also drives a clean switch vector for LED mirroring.

---
 rtl/sw_key_decoder_pkg.sv | 34 +++
 rtl/sw_key_decoder_if.sv | 34 +++
 rtl/sw_key_decoder_debounce.sv | 57 +++++
 rtl/sw_key_decoder.sv | 76 +++++++
 tb/tb_sw_key_decoder.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sw_key_decoder_pkg.sv
// Shared types and helpers for the switch key decoder: default widths,
// FSM state encoding and one-hot helpers used by the decoder FSM.
package sw_key_pkg;

  localparam int SW_W_DEF  = 16;
  localparam int KEY_W_DEF = 4;

  typedef enum logic {
    IDLE         = 1'b0,
    WAIT_RELEASE = 1'b1
  } key_state_e;

  // OR-reduction encoder: correct only when the caller guarantees a single set bit.
  function automatic logic [KEY_W_DEF-1:0] onehot_to_index(input logic [SW_W_DEF-1:0] onehot);
    logic [KEY_W_DEF-1:0] idx;
    idx = '0;
    for (int i = 0; i < SW_W_DEF; i++) begin
      if (onehot[i]) begin
        idx = idx | KEY_W_DEF'(i);
      end
    end
    return idx;
  endfunction

  function automatic logic is_onehot(input logic [SW_W_DEF-1:0] vec);
    int unsigned ones;
    ones = 0;
    for (int i = 0; i < SW_W_DEF; i++) begin
      ones = ones + 32'(vec[i]);
    end
    return (ones == 1);
  endfunction

endpackage

// File: rtl/sw_key_decoder_if.sv
// Switch-in / key-event-out bundle between the board switches and the game core.
interface sw_key_if
  import sw_key_pkg::*;
#(
  parameter int SW_W  = SW_W_DEF,
  parameter int KEY_W = KEY_W_DEF
);

  logic [SW_W-1:0]  sw;
  logic             key_valid;
  logic [KEY_W-1:0] key_code;
  logic             key_err;
  logic             key_held;
  logic [SW_W-1:0]  sw_clean;

  modport master (
    output sw,
    input  key_valid,
    input  key_code,
    input  key_err,
    input  key_held,
    input  sw_clean
  );

  modport slave (
    input  sw,
    output key_valid,
    output key_code,
    output key_err,
    output key_held,
    output sw_clean
  );

endinterface

// File: rtl/sw_key_decoder_debounce.sv
// Two-flop synchroniser plus a whole-vector stability counter: sw_clean only
// takes a new value after sw_s has held it for DEBOUNCE_CYCLES+1 samples.
module sw_debounce #(
  parameter int SW_W            = 16,
  parameter int DEBOUNCE_CYCLES = 50
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SW_W-1:0] sw,
  output logic [SW_W-1:0] sw_clean
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SW_W-1:0]  sync1_q, sync1_d;
  logic [SW_W-1:0]  sync2_q, sync2_d;
  logic [SW_W-1:0]  prev_q, prev_d;
  logic [SW_W-1:0]  clean_q, clean_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any movement on sw_s, or nothing new to accept, restarts the stability count.
  always_comb begin
    sync1_d = sw;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    clean_d = clean_q;
    cnt_d   = cnt_q;
    if ((sync2_q != prev_q) || (sync2_q == clean_q)) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      clean_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      clean_q <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      clean_q <= clean_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sw_clean = clean_q;

endmodule

// File: rtl/sw_key_decoder.sv
// Turns a debounced one-hot switch press into a single-cycle key event with
// its index; multi-switch presses raise key_err, and every key needs a full release.
module sw_key_decoder
  import sw_key_pkg::*;
#(
  parameter int SW_W            = SW_W_DEF,
  parameter int KEY_W           = KEY_W_DEF,
  parameter int DEBOUNCE_CYCLES = 50
) (
  input  logic    clk,
  input  logic    rst,
  sw_key_if.slave bus
);

  logic [SW_W-1:0]  sw_clean;
  key_state_e       state_q, state_d;
  logic             key_valid_q, key_valid_d;
  logic             key_err_q, key_err_d;
  logic [KEY_W-1:0] key_code_q, key_code_d;

  sw_debounce #(
    .SW_W            (SW_W),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .rst      (rst),
    .sw       (bus.sw),
    .sw_clean (sw_clean)
  );

  // Events fire only from IDLE, so a held or reshuffled press never repeats.
  always_comb begin
    state_d     = state_q;
    key_valid_d = 1'b0;
    key_err_d   = 1'b0;
    key_code_d  = key_code_q;
    case (state_q)
      IDLE: begin
        if (is_onehot(sw_clean)) begin
          key_valid_d = 1'b1;
          key_code_d  = onehot_to_index(sw_clean);
          state_d     = WAIT_RELEASE;
        end else if (sw_clean != '0) begin
          key_err_d = 1'b1;
          state_d   = WAIT_RELEASE;
        end
      end
      WAIT_RELEASE: begin
        if (sw_clean == '0) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      key_valid_q <= 1'b0;
      key_err_q   <= 1'b0;
      key_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      key_valid_q <= key_valid_d;
      key_err_q   <= key_err_d;
      key_code_q  <= key_code_d;
    end
  end

  assign bus.key_valid = key_valid_q;
  assign bus.key_err   = key_err_q;
  assign bus.key_code  = key_code_q;
  assign bus.key_held  = |sw_clean;
  assign bus.sw_clean  = sw_clean;

endmodule

// File: tb/tb_sw_key_decoder.sv
// Self-checking bench for sw_key_decoder: directed scenarios with literal
// expectations, then random switch activity checked against a behavioural model.
module tb_sw_key_decoder;

  localparam int DEB = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sw_key_if #(.SW_W(16), .KEY_W(4)) bus ();

  sw_key_decoder #(
    .SW_W            (16),
    .KEY_W           (4),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  // Model state: synchroniser pipe, run length of the synchronised value, expected outputs.
  logic [15:0] p1, p2, last_s, m_clean;
  int          run;
  bit          busy, ready;
  logic        m_valid, m_err;
  logic [3:0]  m_code;

  // Observations gathered by the compare process for the directed checks.
  int          valid_cnt = 0;
  int          err_cnt   = 0;
  int          valid_edge = 0;
  int          held_fall_edge = 0;
  bit          held_prev = 1'b0;
  bit          clean_seen = 1'b0;
  logic [3:0]  code_log[$];
  int          last_start = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] v, input int cycles);
    @(negedge clk);
    bus.sw = v;
    last_start = cyc + 1;
    repeat (cycles - 1) @(negedge clk);
  endtask

  task automatic applyReset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [3:0] index_of(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  // Behavioural model: a key is decided from the clean vector of the previous
  // cycle; the clean vector adopts a synchronised value after DEB+1 equal samples.
  initial begin
    p1 = '0; p2 = '0; last_s = '0; m_clean = '0; run = 0;
    busy = 1'b0; ready = 1'b0; m_valid = 1'b0; m_err = 1'b0; m_code = '0;
    forever begin
      logic [15:0] s;
      int ones;
      @(posedge clk);
      cyc++;
      if (rst) begin
        p1 = '0; p2 = '0; last_s = '0; m_clean = '0; run = 0;
        busy = 1'b0; m_valid = 1'b0; m_err = 1'b0; m_code = '0;
        ready = 1'b1;
      end else begin
        s  = p2;
        p2 = p1;
        p1 = bus.sw;
        m_valid = 1'b0;
        m_err   = 1'b0;
        ones = $countones(m_clean);
        if (!busy) begin
          if (ones == 1) begin
            m_valid = 1'b1;
            m_code  = index_of(m_clean);
            busy    = 1'b1;
          end else if (ones > 1) begin
            m_err = 1'b1;
            busy  = 1'b1;
          end
        end else if (m_clean == '0) begin
          busy = 1'b0;
        end
        if (s == last_s) begin
          run++;
        end else begin
          run = 1;
          last_s = s;
        end
        if (run == DEB + 1 && s != m_clean) m_clean = s;
      end
    end
  end

  // Compare process: every cycle after the first reset, outputs must equal the model.
  initial begin
    forever begin
      @(negedge clk);
      if (ready) begin
        checkOutput("key_valid", 32'(bus.key_valid), 32'(m_valid));
        checkOutput("key_err",   32'(bus.key_err),   32'(m_err));
        checkOutput("key_code",  32'(bus.key_code),  32'(m_code));
        checkOutput("sw_clean",  32'(bus.sw_clean),  32'(m_clean));
        checkOutput("key_held",  32'(bus.key_held),  32'(|m_clean));
        if (bus.key_valid && bus.key_err) checkOutput("valid_err_exclusive", 32'(1), 32'(0));
        if (bus.key_valid === 1'b1) begin
          valid_cnt++;
          valid_edge = cyc;
          code_log.push_back(bus.key_code);
        end
        if (bus.key_err === 1'b1) err_cnt++;
        if (held_prev && !bus.key_held) held_fall_edge = cyc;
        held_prev = bus.key_held;
        if (bus.sw_clean != '0) clean_seen = 1'b1;
      end
    end
  end

  initial begin
    int v0, e0, t_start, t_rel;
    bus.sw = '0;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    $display("[TB] reset released");
    #1;
    checkOutput("reset_key_code", 32'(bus.key_code), 32'(0));
    checkOutput("reset_sw_clean", 32'(bus.sw_clean), 32'(0));

    // 1: single press of sw[9]
    v0 = valid_cnt; e0 = err_cnt;
    applyStimulus(16'd512, 100);
    t_start = last_start;
    applyStimulus(16'd0, 100);
    t_rel = last_start;
    #1;
    checkOutput("t1_valid_count", 32'(valid_cnt - v0), 32'(1));
    checkOutput("t1_latency", 32'(valid_edge - t_start), 32'(23));
    checkOutput("t1_code", 32'(code_log[v0]), 32'(9));
    checkOutput("t1_err_count", 32'(err_cnt - e0), 32'(0));
    checkOutput("t1_held_fall", 32'(held_fall_edge - t_rel), 32'(22));

    // 2: two keys separated by a release
    v0 = valid_cnt;
    applyStimulus(16'd256, 100);
    applyStimulus(16'd0, 100);
    #1;
    checkOutput("t2_code_hold", 32'(bus.key_code), 32'(8));
    applyStimulus(16'd2048, 100);
    applyStimulus(16'd0, 100);
    #1;
    checkOutput("t2_valid_count", 32'(valid_cnt - v0), 32'(2));
    checkOutput("t2_code_first", 32'(code_log[v0]), 32'(8));
    checkOutput("t2_code_second", 32'(code_log[v0 + 1]), 32'(11));

    // 3: glitch shorter than the debounce window
    v0 = valid_cnt;
    clean_seen = 1'b0;
    applyStimulus(16'd4, 15);
    applyStimulus(16'd0, 100);
    #1;
    checkOutput("t3_valid_count", 32'(valid_cnt - v0), 32'(0));
    checkOutput("t3_clean_seen", 32'(clean_seen), 32'(0));

    // 4: two switches at once, then a legal key
    v0 = valid_cnt; e0 = err_cnt;
    applyStimulus(16'h0104, 100);
    applyStimulus(16'd0, 100);
    #1;
    checkOutput("t4_err_count", 32'(err_cnt - e0), 32'(1));
    checkOutput("t4_valid_count", 32'(valid_cnt - v0), 32'(0));
    checkOutput("t4_code_kept", 32'(bus.key_code), 32'(11));
    applyStimulus(16'd1024, 100);
    applyStimulus(16'd0, 100);
    #1;
    checkOutput("t4_code_after", 32'(code_log[code_log.size() - 1]), 32'(10));

    // 5: changing the press without a full release
    v0 = valid_cnt; e0 = err_cnt;
    applyStimulus(16'd256, 100);
    applyStimulus(16'd2304, 100);
    applyStimulus(16'd2048, 100);
    applyStimulus(16'd0, 100);
    #1;
    checkOutput("t5_valid_count", 32'(valid_cnt - v0), 32'(1));
    checkOutput("t5_code", 32'(code_log[v0]), 32'(8));
    checkOutput("t5_err_count", 32'(err_cnt - e0), 32'(0));

    // 6: reset in the middle of a held press
    applyStimulus(16'h8000, 100);
    #1;
    checkOutput("t6_code_before", 32'(bus.key_code), 32'(15));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t6_clear_held", 32'(bus.key_held), 32'(0));
    checkOutput("t6_clear_clean", 32'(bus.sw_clean), 32'(0));
    checkOutput("t6_clear_code", 32'(bus.key_code), 32'(0));
    rst = 1'b0;
    t_start = cyc + 1;
    v0 = valid_cnt;
    repeat (60) @(negedge clk);
    applyStimulus(16'd0, 100);
    #1;
    checkOutput("t6_valid_count", 32'(valid_cnt - v0), 32'(1));
    checkOutput("t6_latency", 32'(valid_edge - t_start), 32'(23));
    checkOutput("t6_code", 32'(code_log[v0]), 32'(15));

    // Random phase: mixed one-hot, multi-bit, glitches and occasional resets.
    $display("[TB] random phase");
    for (int seg = 0; seg < 60; seg++) begin
      logic [15:0] v;
      int kind, dur;
      kind = int'($urandom_range(0, 6));
      dur  = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 25)) : int'($urandom_range(21, 80));
      case (kind)
        0, 1:    v = '0;
        2, 3:    v = 16'(1) << $urandom_range(0, 15);
        4:       v = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
        5:       v = 16'($urandom);
        default: v = bus.sw;
      endcase
      if (kind == 6) applyReset(int'($urandom_range(1, 2)));
      else applyStimulus(v, dur);
    end
    applyStimulus(16'd0, 60);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
